// File: rtl/pong_game.sv
// Pong game engine and pixel generator. Sits directly behind the VGA timing
// generator: game state advances once per frame on the vsync falling edge,
// and the pixel path turns the current hcount/vcount into a registered
// colour with the syncs delayed to match.
module pong_game #(
  parameter int PADDLE_W     = 8,
  parameter int PADDLE_H     = 64,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_SPEED = 4,
  parameter int BALL_SPEED   = 2,
  parameter int LEFT_X       = 16,
  parameter int RIGHT_X      = 616,
  parameter int SCORE_MAX    = 9,
  parameter int POINT_FRAMES = 60
) (
  input  logic        clk_25,
  input  logic        rst_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic        btn_l_up,
  input  logic        btn_l_dn,
  input  logic        btn_r_up,
  input  logic        btn_r_dn,
  input  logic        start,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [11:0] rgb,
  output logic [3:0]  score_l,
  output logic [3:0]  score_r,
  output logic        game_over
);

  localparam logic [10:0] X_CENTRE   = 11'((640 - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_CENTRE   = 10'((480 - BALL_SIZE) / 2);
  localparam logic [9:0]  PAD_RESET  = 10'((480 - PADDLE_H) / 2);
  localparam logic [9:0]  PAD_MAX    = 10'(480 - PADDLE_H);
  localparam logic [9:0]  PAD_STEP   = 10'(PADDLE_SPEED);
  localparam logic [9:0]  PAD_HEIGHT = 10'(PADDLE_H);
  localparam logic [10:0] BALL_W     = 11'(BALL_SIZE);
  localparam logic [9:0]  BALL_H     = 10'(BALL_SIZE);
  localparam logic [10:0] STEP_X     = 11'(BALL_SPEED);
  localparam logic [9:0]  STEP_Y     = 10'(BALL_SPEED);
  localparam logic [9:0]  BALL_Y_MAX = 10'(480 - BALL_SIZE);
  localparam logic [10:0] L_HIT_X    = 11'(LEFT_X + PADDLE_W);
  localparam logic [10:0] R_HIT_X    = 11'(RIGHT_X - BALL_SIZE);
  localparam logic [10:0] R_MISS_X   = 11'(640 - BALL_SIZE);
  localparam logic [10:0] LP_X0      = 11'(LEFT_X);
  localparam logic [10:0] LP_X1      = 11'(LEFT_X + PADDLE_W);
  localparam logic [10:0] RP_X0      = 11'(RIGHT_X);
  localparam logic [10:0] RP_X1      = 11'(RIGHT_X + PADDLE_W);
  localparam logic [3:0]  SMAX       = 4'(SCORE_MAX);
  localparam logic [7:0]  CNT_LAST   = 8'(POINT_FRAMES - 1);

  typedef enum logic [1:0] {SERVE, PLAY, POINT, GAMEOVER} state_t;

  state_t      state, state_next;
  logic [9:0]  pad_l, pad_r, pad_l_next, pad_r_next;
  logic [10:0] ball_x, ball_x_next, nx;
  logic [9:0]  ball_y, ball_y_next, ny;
  logic        dx, dy, dx_next, dy_next;    // 1 = increasing coordinate
  logic        serve_dir, serve_dir_next;   // direction of the next serve
  logic [3:0]  score_l_next, score_r_next;
  logic [7:0]  cnt, cnt_next;
  logic        frame_tick;
  logic        hit_l, hit_r;
  logic        in_ball, in_pad_l, in_pad_r, in_line;
  logic [11:0] rgb_next;

  // vga_vsync doubles as the delayed vsync used for edge detection
  assign frame_tick = vga_vsync & ~vsync;
  assign game_over  = (state == GAMEOVER);

  // Candidate positions; only used when the step cannot underflow
  assign nx = dx ? ball_x + STEP_X : ball_x - STEP_X;
  assign ny = dy ? ball_y + STEP_Y : ball_y - STEP_Y;

  assign hit_l = (ball_y + BALL_H > pad_l) && (ball_y < pad_l + PAD_HEIGHT);
  assign hit_r = (ball_y + BALL_H > pad_r) && (ball_y < pad_r + PAD_HEIGHT);

  function automatic logic [9:0] paddle_step(input logic [9:0] y, input logic up, input logic dn);
    paddle_step = y;
    if (up && !dn)
      paddle_step = (y < PAD_STEP) ? 10'd0 : y - PAD_STEP;
    else if (dn && !up)
      paddle_step = (y > PAD_MAX - PAD_STEP) ? PAD_MAX : y + PAD_STEP;
  endfunction

  // Next-frame game state: paddles, ball motion, collisions, scoring, FSM
  always_comb begin
    state_next     = state;
    ball_x_next    = ball_x;
    ball_y_next    = ball_y;
    dx_next        = dx;
    dy_next        = dy;
    serve_dir_next = serve_dir;
    score_l_next   = score_l;
    score_r_next   = score_r;
    cnt_next       = cnt;
    pad_l_next     = paddle_step(pad_l, btn_l_up, btn_l_dn);
    pad_r_next     = paddle_step(pad_r, btn_r_up, btn_r_dn);
    case (state)
      SERVE: begin
        ball_x_next = X_CENTRE;
        ball_y_next = Y_CENTRE;
        if (start) state_next = PLAY;
      end
      PLAY: begin
        if (!dy && ball_y <= STEP_Y) begin
          ball_y_next = 10'd0;
          dy_next     = 1'b1;
        end else if (dy && ball_y >= BALL_Y_MAX - STEP_Y) begin
          ball_y_next = BALL_Y_MAX;
          dy_next     = 1'b0;
        end else begin
          ball_y_next = ny;
        end
        // Misses are tested first so they win over a paddle hit
        if (!dx && ball_x <= STEP_X) begin
          if (score_r < SMAX) score_r_next = score_r + 4'd1;
          serve_dir_next = 1'b0;
          cnt_next       = 8'd0;
          state_next     = POINT;
        end else if (dx && ball_x >= R_MISS_X - STEP_X) begin
          if (score_l < SMAX) score_l_next = score_l + 4'd1;
          serve_dir_next = 1'b1;
          cnt_next       = 8'd0;
          state_next     = POINT;
        end else if (!dx && nx <= L_HIT_X && hit_l) begin
          ball_x_next = L_HIT_X;
          dx_next     = 1'b1;
        end else if (dx && nx >= R_HIT_X && hit_r) begin
          ball_x_next = R_HIT_X;
          dx_next     = 1'b0;
        end else begin
          ball_x_next = nx;
        end
      end
      POINT: begin
        if (cnt == CNT_LAST) begin
          ball_x_next = X_CENTRE;
          ball_y_next = Y_CENTRE;
          dx_next     = serve_dir;
          state_next  = (score_l == SMAX || score_r == SMAX) ? GAMEOVER : SERVE;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      GAMEOVER: begin
        if (start) begin
          score_l_next = 4'd0;
          score_r_next = 4'd0;
          ball_x_next  = X_CENTRE;
          ball_y_next  = Y_CENTRE;
          state_next   = SERVE;
        end
      end
      default: state_next = SERVE;
    endcase
  end

  // FSM state register, advanced once per frame
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n)          state <= SERVE;
    else if (frame_tick) state <= state_next;
  end

  // Game datapath registers, advanced once per frame
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      pad_l     <= PAD_RESET;
      pad_r     <= PAD_RESET;
      ball_x    <= X_CENTRE;
      ball_y    <= Y_CENTRE;
      dx        <= 1'b1;
      dy        <= 1'b1;
      serve_dir <= 1'b1;
      score_l   <= 4'd0;
      score_r   <= 4'd0;
      cnt       <= 8'd0;
    end else if (frame_tick) begin
      pad_l     <= pad_l_next;
      pad_r     <= pad_r_next;
      ball_x    <= ball_x_next;
      ball_y    <= ball_y_next;
      dx        <= dx_next;
      dy        <= dy_next;
      serve_dir <= serve_dir_next;
      score_l   <= score_l_next;
      score_r   <= score_r_next;
      cnt       <= cnt_next;
    end
  end

  assign in_ball  = (hcount >= ball_x) && (hcount < ball_x + BALL_W) &&
                    (vcount >= ball_y) && (vcount < ball_y + BALL_H);
  assign in_pad_l = (hcount >= LP_X0) && (hcount < LP_X1) &&
                    (vcount >= pad_l) && (vcount < pad_l + PAD_HEIGHT);
  assign in_pad_r = (hcount >= RP_X0) && (hcount < RP_X1) &&
                    (vcount >= pad_r) && (vcount < pad_r + PAD_HEIGHT);
  assign in_line  = (hcount == 11'd319 || hcount == 11'd320) && !vcount[3];

  // Pixel colour by object priority
  always_comb begin
    rgb_next = 12'h000;
    if (blank)         rgb_next = 12'h000;
    else if (in_ball)  rgb_next = 12'hFFF;
    else if (in_pad_l) rgb_next = 12'h00F;
    else if (in_pad_r) rgb_next = 12'hF00;
    else if (in_line)  rgb_next = 12'h888;
  end

  // Registered pixel and syncs, aligned with one clock of latency
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      rgb       <= 12'h000;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      rgb       <= rgb_next;
      vga_hsync <= hsync;
      vga_vsync <= vsync;
    end
  end

endmodule

// File: tb/tb_pong_game.sv
// Self-checking bench for pong_game: randomized pixel probes and buttons over
// short synthetic frames, checked by a queue-based scoreboard against a
// behavioural game model.
module tb_pong_game;

  localparam int FL = 8;  // clocks per synthetic frame, vsync low for the last two
  localparam int S_SERVE = 0, S_PLAY = 1, S_POINT = 2, S_GO = 3;

  logic        clk_25 = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic        btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start;
  logic        vga_hsync, vga_vsync, game_over;
  logic [11:0] rgb;
  logic [3:0]  score_l, score_r;

  pong_game dut (
    .clk_25(clk_25), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .hsync(hsync), .vsync(vsync), .blank(blank),
    .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
    .start(start), .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .rgb(rgb),
    .score_l(score_l), .score_r(score_r), .game_over(game_over)
  );

  always #20 clk_25 = ~clk_25;

  typedef struct {
    logic [11:0] rgb;
    logic        hs, vs, go, tick;
    logic [3:0]  sl, sr;
    int          h, v;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  bit dut_go_seen = 0;

  // Behavioural model of the game
  int m_state, m_bx, m_by, m_dxs, m_dys, m_pl, m_pr, m_sl, m_sr, m_cnt, m_serve;
  bit m_vs_prev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_SERVE; m_bx = 316; m_by = 236; m_dxs = 1; m_dys = 1;
    m_pl = 208; m_pr = 208; m_sl = 0; m_sr = 0; m_cnt = 0; m_serve = 1; m_vs_prev = 1;
  endtask

  function automatic int pstep(int y, bit up, bit dn);
    if (up && !dn) return (y - 4 < 0) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  function automatic bit overlaps(int by, int py);
    return (by + 8 > py) && (by < py + 64);
  endfunction

  task automatic model_tick(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    int opl, opr, oby, nx, ny;
    opl = m_pl; opr = m_pr; oby = m_by;
    m_pl = pstep(m_pl, lu, ld);
    m_pr = pstep(m_pr, ru, rd);
    case (m_state)
      S_SERVE: begin
        m_bx = 316; m_by = 236;
        if (st) m_state = S_PLAY;
      end
      S_PLAY: begin
        nx = m_bx + 2 * m_dxs;
        ny = m_by + 2 * m_dys;
        if (ny <= 0) begin m_by = 0; m_dys = 1; end
        else if (ny >= 472) begin m_by = 472; m_dys = -1; end
        else m_by = ny;
        if (nx <= 0) begin
          if (m_sr < 9) m_sr++;
          m_serve = -1; m_cnt = 0; m_state = S_POINT;
        end else if (nx >= 632) begin
          if (m_sl < 9) m_sl++;
          m_serve = 1; m_cnt = 0; m_state = S_POINT;
        end else if (m_dxs < 0 && nx <= 24 && overlaps(oby, opl)) begin
          m_bx = 24; m_dxs = 1;
        end else if (m_dxs > 0 && nx + 8 >= 616 && overlaps(oby, opr)) begin
          m_bx = 608; m_dxs = -1;
        end else begin
          m_bx = nx;
        end
      end
      S_POINT: begin
        if (m_cnt == 59) begin
          m_bx = 316; m_by = 236; m_dxs = m_serve;
          m_state = (m_sl == 9 || m_sr == 9) ? S_GO : S_SERVE;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (st) begin
          m_sl = 0; m_sr = 0; m_bx = 316; m_by = 236; m_state = S_SERVE;
        end
      end
    endcase
  endtask

  function automatic logic [11:0] ref_pixel(int h, int v, bit bl);
    if (bl) return 12'h000;
    if (h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8) return 12'hFFF;
    if (h >= 16 && h < 24 && v >= m_pl && v < m_pl + 64) return 12'h00F;
    if (h >= 616 && h < 624 && v >= m_pr && v < m_pr + 64) return 12'hF00;
    if ((h == 319 || h == 320) && ((v / 8) % 2 == 0)) return 12'h888;
    return 12'h000;
  endfunction

  // One pixel clock of stimulus; the expected response goes to the scoreboard
  task automatic drive_cycle(input int pos, input bit force_ball);
    int r, h, v;
    bit bl, tick;
    exp_t e;
    @(negedge clk_25);
    vsync = (pos >= FL - 2) ? 1'b0 : 1'b1;
    hsync = force_ball ? 1'b0 : 1'($urandom_range(0, 1));
    bl = 0;
    r = force_ball ? 0 : int'($urandom_range(0, 9));
    case (r)
      0, 1, 2, 8, 9: begin h = m_bx + int'($urandom_range(0, 11)) - 2; v = m_by + int'($urandom_range(0, 11)) - 2; end
      3: begin h = 14 + int'($urandom_range(0, 11)); v = m_pl + int'($urandom_range(0, 67)) - 2; end
      4: begin h = 614 + int'($urandom_range(0, 11)); v = m_pr + int'($urandom_range(0, 67)) - 2; end
      5: begin h = 318 + int'($urandom_range(0, 3)); v = int'($urandom_range(0, 479)); end
      6: begin h = int'($urandom_range(0, 639)); v = int'($urandom_range(0, 479)); end
      default: begin h = int'($urandom_range(0, 794)); v = int'($urandom_range(0, 527)); bl = 1; end
    endcase
    if (force_ball) begin h = m_bx + 3; v = m_by + 3; end
    if (h < 0) h = 0;
    if (h > 794) h = 794;
    if (v < 0) v = 0;
    if (v > 527) v = 527;
    if (h > 639 || v > 479) bl = 1;
    hcount = 11'(h); vcount = 10'(v); blank = bl;
    e.rgb = ref_pixel(h, v, bl);
    e.hs = hsync; e.vs = vsync; e.h = h; e.v = v;
    tick = m_vs_prev && !vsync;
    m_vs_prev = vsync;
    if (tick) model_tick(btn_l_up, btn_l_dn, btn_r_up, btn_r_dn, start);
    e.tick = tick;
    e.sl = 4'(m_sl); e.sr = 4'(m_sr); e.go = (m_state == S_GO);
    q.push_back(e);
  endtask

  task automatic do_frame(input bit lu, input bit ld, input bit ru, input bit rd, input bit st);
    btn_l_up = lu; btn_l_dn = ld; btn_r_up = ru; btn_r_dn = rd; start = st;
    for (int p = 0; p < FL; p++) drive_cycle(p, 1'b0);
  endtask

  // Scoreboard monitor: one expected entry per driven clock
  always @(posedge clk_25) begin
    exp_t e;
    #1;
    if (rst_n && q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("rgb@%0d,%0d", e.h, e.v), 32'(rgb), 32'(e.rgb));
      chk("syncs", 32'({vga_hsync, vga_vsync}), 32'({e.hs, e.vs}));
      if (e.tick) begin
        chk("score_l", 32'(score_l), 32'(e.sl));
        chk("score_r", 32'(score_r), 32'(e.sr));
        chk("game_over", 32'(game_over), 32'(e.go));
        if (game_over) dut_go_seen = 1;
      end
    end
  end

  initial begin
    #(40 * 95000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit lu, ld, ru, rd, st, seen_go, restarted;
    rst_n = 0; hsync = 0; vsync = 1; blank = 0; hcount = 11'd318; vcount = 10'd238;
    btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0; start = 0;
    model_reset();
    repeat (3) @(negedge clk_25);
    chk("reset rgb", 32'(rgb), 32'h0);
    chk("reset syncs", 32'({vga_hsync, vga_vsync}), 32'h3);
    chk("reset scores", 32'({score_l, score_r}), 32'h0);
    chk("reset game_over", 32'(game_over), 32'h0);
    hsync = 1;
    rst_n = 1;

    // Idle frames: ball parked at centre
    repeat (2) do_frame(0, 0, 0, 0, 0);
    // Left paddle driven into the top stop, then both buttons hold both paddles
    repeat (60) do_frame(1, 0, 0, 1, 0);
    repeat (5) do_frame(1, 1, 1, 1, 0);

    // Randomized play until a game has ended and been restarted
    seen_go = 0; restarted = 0;
    for (int f = 0; f < 9000 && !restarted; f++) begin
      if (f % 6 == 0) begin
        lu = 1'($urandom_range(0, 1)); ld = 1'($urandom_range(0, 1));
        ru = 1'($urandom_range(0, 1)); rd = 1'($urandom_range(0, 1));
        st = ($urandom_range(0, 3) != 0);
      end
      do_frame(lu, ld, ru, rd, st);
      if (m_state == S_GO) seen_go = 1;
      if (seen_go && m_state == S_SERVE) restarted = 1;
    end
    chk("game ended and restarted", 32'(restarted), 32'h1);
    chk("dut game_over observed", 32'(dut_go_seen), 32'h1);

    // Get into PLAY, then reset in the middle of a line
    repeat (40) do_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1);
    drive_cycle(3, 1'b1);
    @(posedge clk_25);
    #5;
    rst_n = 0;
    #1;
    chk("midframe reset rgb", 32'(rgb), 32'h0);
    chk("midframe reset syncs", 32'({vga_hsync, vga_vsync}), 32'h3);
    chk("midframe reset scores", 32'({score_l, score_r}), 32'h0);
    chk("midframe reset game_over", 32'(game_over), 32'h0);
    repeat (3) @(negedge clk_25);
    rst_n = 1;
    model_reset();
    repeat (3) do_frame(0, 0, 0, 0, 0);
    repeat (20) do_frame(0, 1, 1, 0, 1);

    repeat (2) @(posedge clk_25);
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
